// File: rtl/yi_writer_s.sv
// yi_writer_s: packs a stream of Y elements (16/32/64-bit) into 64-bit AXI4
// single-beat writes starting at YVAL_BASE_ADDR, limiting bursts in flight
// to MAX_OUTSTANDING and reporting completion once every B response is back.
//
// Optional feature: define YI_WRITER_RESP_CHECK_EN to make Write_Err a sticky
// flag for non-OKAY B responses; otherwise bresp is ignored and Write_Err = 0.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   Write_Begin/Write_Length  start pulse and element count (sampled on start)
//   Ctrl_sig_Yi               element size: 0=16b, 1=32b, 2/3=64b
//   Yi_valid/Yi_ready/Yi_data element stream, right-aligned in Yi_data
//   Write_Done, Write_Err     run complete, sticky response error
//   m_axi_Yi_aw*/w*/b*        AXI4 write master (single-beat INCR, 8 bytes)
//
// state | meaning
// IDLE  | waiting for Write_Begin after reset
// RUN   | accepting elements and issuing beats
// DRAIN | all beats issued, waiting for outstanding B responses
// DONE  | run complete, Write_Done high, new Write_Begin accepted
module yi_writer_s #(
  parameter logic [31:0] YVAL_BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Write_Begin,
  input  logic [31:0] Write_Length,
  input  logic [1:0]  Ctrl_sig_Yi,
  input  logic        Yi_valid,
  output logic        Yi_ready,
  input  logic [63:0] Yi_data,
  output logic        Write_Done,
  output logic        Write_Err,
  output logic        m_axi_Yi_awid,
  output logic [47:0] m_axi_Yi_awaddr,
  output logic [7:0]  m_axi_Yi_awlen,
  output logic [2:0]  m_axi_Yi_awsize,
  output logic [1:0]  m_axi_Yi_awburst,
  output logic        m_axi_Yi_awlock,
  output logic [3:0]  m_axi_Yi_awcache,
  output logic [2:0]  m_axi_Yi_awprot,
  output logic [3:0]  m_axi_Yi_awqos,
  output logic        m_axi_Yi_awvalid,
  input  logic        m_axi_Yi_awready,
  output logic [63:0] m_axi_Yi_wdata,
  output logic [7:0]  m_axi_Yi_wstrb,
  output logic        m_axi_Yi_wlast,
  output logic        m_axi_Yi_wvalid,
  input  logic        m_axi_Yi_wready,
  input  logic        m_axi_Yi_bid,
  input  logic [1:0]  m_axi_Yi_bresp,
  input  logic        m_axi_Yi_bvalid,
  output logic        m_axi_Yi_bready
);

  localparam logic [8:0] MAX_OUT = 9'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q;
  logic [31:0] len_q;
  logic [31:0] i_q;
  logic [63:0] buf_q;
  logic [7:0]  strb_q;
  logic        pending_q;
  logic        last_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic [47:0] awaddr_q;
  logic [7:0]  out_q;
  logic [7:0]  out_d;

  logic [1:0]  size_log2;
  logic [2:0]  lane_mask;
  logic [7:0]  elem_strb;
  logic [63:0] elem_mask;
  logic [2:0]  lane;
  logic [2:0]  byte_off;
  logic [63:0] lane_data;
  logic [7:0]  lane_strb;
  logic [31:0] i_next;
  logic        last_elem;
  logic        beat_full;
  logic [47:0] beat_addr_d;
  logic        begin_ok;
  logic        accept;
  logic        aw_fire;
  logic        w_fire;
  logic        issue;
  logic        b_evt;

  always_comb begin
    size_log2 = 2'd3;
    lane_mask = 3'b000;
    elem_strb = 8'hFF;
    elem_mask = {64{1'b1}};
    case (Ctrl_sig_Yi)
      2'd0: begin
        size_log2 = 2'd1;
        lane_mask = 3'b011;
        elem_strb = 8'h03;
        elem_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd1: begin
        size_log2 = 2'd2;
        lane_mask = 3'b001;
        elem_strb = 8'h0F;
        elem_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Beats are 8-byte aligned, so the lane is simply the low index bits.
  assign lane        = i_q[2:0] & lane_mask;
  assign byte_off    = lane << size_log2;
  assign lane_data   = (Yi_data & elem_mask) << {byte_off, 3'b000};
  assign lane_strb   = elem_strb << byte_off;
  assign i_next      = i_q + 32'd1;
  assign last_elem   = (i_next == len_q);
  assign beat_full   = (lane == lane_mask);
  // Address of the beat holding element i equals that of its first element.
  assign beat_addr_d = 48'(YVAL_BASE_ADDR) + ((48'(i_q) << size_log2) & ~48'h7);

  assign begin_ok = Write_Begin & ((state_q == IDLE) | (state_q == DONE));
  assign accept   = Yi_valid & Yi_ready;
  assign aw_fire  = awvalid_q & m_axi_Yi_awready;
  assign w_fire   = wvalid_q & m_axi_Yi_wready;
  // A beat is issued once both channels have handshaken, in either order.
  assign issue    = pending_q & (aw_fire | aw_done_q) & (w_fire | w_done_q);
  assign b_evt    = m_axi_Yi_bvalid;

  always_comb begin
    out_d = out_q;
    if (issue & ~b_evt) begin
      out_d = out_q + 8'd1;
    end else if (~issue & b_evt & (out_q != 8'd0)) begin
      out_d = out_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      i_q       <= '0;
      buf_q     <= '0;
      strb_q    <= '0;
      pending_q <= 1'b0;
      last_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      out_q     <= '0;
    end else begin
      out_q <= out_d;
      case (state_q)
        IDLE, DONE: begin
          if (begin_ok) begin
            len_q     <= Write_Length;
            i_q       <= '0;
            buf_q     <= '0;
            strb_q    <= '0;
            pending_q <= 1'b0;
            last_q    <= 1'b0;
            state_q   <= (Write_Length == 32'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            buf_q  <= buf_q | lane_data;
            strb_q <= strb_q | lane_strb;
            i_q    <= i_next;
            if (beat_full | last_elem) begin
              pending_q <= 1'b1;
              last_q    <= last_elem;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              awaddr_q  <= beat_addr_d;
            end
          end
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (issue) begin
            pending_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            buf_q     <= '0;
            strb_q    <= '0;
            if (last_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_q == 8'd0) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef YI_WRITER_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (b_evt && (m_axi_Yi_bresp != 2'b00)) begin
      err_q <= 1'b1;
    end else if (begin_ok) begin
      err_q <= 1'b0;
    end
  end

  assign Write_Err = err_q;
`else
  assign Write_Err = 1'b0;
`endif

  // Response ID is always 0 and bresp only matters with the error check.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_Yi_bid, m_axi_Yi_bresp};

  assign Yi_ready   = (state_q == RUN) & ~pending_q & ({1'b0, out_q} < MAX_OUT);
  assign Write_Done = (state_q == DONE);

  assign m_axi_Yi_awid    = 1'b0;
  assign m_axi_Yi_awaddr  = awaddr_q;
  assign m_axi_Yi_awlen   = 8'd0;
  assign m_axi_Yi_awsize  = 3'd3;
  assign m_axi_Yi_awburst = 2'b01;
  assign m_axi_Yi_awlock  = 1'b0;
  assign m_axi_Yi_awcache = 4'b0011;
  assign m_axi_Yi_awprot  = 3'd0;
  assign m_axi_Yi_awqos   = 4'd0;
  assign m_axi_Yi_awvalid = awvalid_q;
  assign m_axi_Yi_wdata   = buf_q;
  assign m_axi_Yi_wstrb   = strb_q;
  assign m_axi_Yi_wlast   = 1'b1;
  assign m_axi_Yi_wvalid  = wvalid_q;
  assign m_axi_Yi_bready  = 1'b1;

endmodule

// File: tb/tb_yi_writer_s.sv
module tb_yi_writer_s;

  localparam logic [47:0] YBASE = 48'h0000_4000_0000;
  localparam int MAXO = 2;
`ifdef YI_WRITER_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        Write_Begin;
  logic [31:0] Write_Length;
  logic [1:0]  Ctrl_sig_Yi;
  logic        Yi_valid;
  logic        Yi_ready;
  logic [63:0] Yi_data;
  logic        Write_Done;
  logic        Write_Err;
  logic        m_axi_Yi_awid;
  logic [47:0] m_axi_Yi_awaddr;
  logic [7:0]  m_axi_Yi_awlen;
  logic [2:0]  m_axi_Yi_awsize;
  logic [1:0]  m_axi_Yi_awburst;
  logic        m_axi_Yi_awlock;
  logic [3:0]  m_axi_Yi_awcache;
  logic [2:0]  m_axi_Yi_awprot;
  logic [3:0]  m_axi_Yi_awqos;
  logic        m_axi_Yi_awvalid;
  logic        m_axi_Yi_awready;
  logic [63:0] m_axi_Yi_wdata;
  logic [7:0]  m_axi_Yi_wstrb;
  logic        m_axi_Yi_wlast;
  logic        m_axi_Yi_wvalid;
  logic        m_axi_Yi_wready;
  logic        m_axi_Yi_bid;
  logic [1:0]  m_axi_Yi_bresp;
  logic        m_axi_Yi_bvalid;
  logic        m_axi_Yi_bready;

  yi_writer_s #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn),
    .Write_Begin(Write_Begin), .Write_Length(Write_Length), .Ctrl_sig_Yi(Ctrl_sig_Yi),
    .Yi_valid(Yi_valid), .Yi_ready(Yi_ready), .Yi_data(Yi_data),
    .Write_Done(Write_Done), .Write_Err(Write_Err),
    .m_axi_Yi_awid(m_axi_Yi_awid), .m_axi_Yi_awaddr(m_axi_Yi_awaddr),
    .m_axi_Yi_awlen(m_axi_Yi_awlen), .m_axi_Yi_awsize(m_axi_Yi_awsize),
    .m_axi_Yi_awburst(m_axi_Yi_awburst), .m_axi_Yi_awlock(m_axi_Yi_awlock),
    .m_axi_Yi_awcache(m_axi_Yi_awcache), .m_axi_Yi_awprot(m_axi_Yi_awprot),
    .m_axi_Yi_awqos(m_axi_Yi_awqos), .m_axi_Yi_awvalid(m_axi_Yi_awvalid),
    .m_axi_Yi_awready(m_axi_Yi_awready),
    .m_axi_Yi_wdata(m_axi_Yi_wdata), .m_axi_Yi_wstrb(m_axi_Yi_wstrb),
    .m_axi_Yi_wlast(m_axi_Yi_wlast), .m_axi_Yi_wvalid(m_axi_Yi_wvalid),
    .m_axi_Yi_wready(m_axi_Yi_wready),
    .m_axi_Yi_bid(m_axi_Yi_bid), .m_axi_Yi_bresp(m_axi_Yi_bresp),
    .m_axi_Yi_bvalid(m_axi_Yi_bvalid), .m_axi_Yi_bready(m_axi_Yi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [1:0]  size;
    int          len;
    int          nbeats;
    logic [47:0] addr_last;
    logic [63:0] data_first;
    logic [63:0] data_last;
    logic [7:0]  strb_first;
    logic [7:0]  strb_last;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [63:0] src[$];
  logic [47:0] aw_log[$];
  logic [63:0] wd_log[$];
  logic [7:0]  ws_log[$];
  int          aw_cyc[$];
  int          w_cyc[$];
  int src_idx, pairs_seen, b_given, b_owed, aw_wait, cyc, err_beat, aw_dly;
  bit b_hold, rnd_mode;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_bench();
    src.delete(); aw_log.delete(); wd_log.delete(); ws_log.delete();
    aw_cyc.delete(); w_cyc.delete();
    src_idx = 0; pairs_seen = 0; b_given = 0; b_owed = 0; aw_wait = 0; cyc = 0;
  endtask

  // One clock cycle of the AXI slave and element source; outputs are
  // sampled 1 time unit after the rising edge.
  task automatic tick();
    int pairs;
    if ((pairs_seen - b_given) >= MAXO) check("ready_when_full", 64'(Yi_ready), 64'd0);
    if (src_idx < src.size() && (!rnd_mode || $urandom_range(3) != 0)) begin
      Yi_valid = 1'b1;
      Yi_data  = src[src_idx];
    end else begin
      Yi_valid = 1'b0;
      Yi_data  = {$urandom, $urandom};
    end
    if (rnd_mode) begin
      m_axi_Yi_awready = ($urandom_range(3) != 0);
      m_axi_Yi_wready  = ($urandom_range(2) != 0);
    end else begin
      m_axi_Yi_awready = (aw_wait >= aw_dly);
      m_axi_Yi_wready  = 1'b1;
    end
    m_axi_Yi_bvalid = (b_owed > 0) && !b_hold && (!rnd_mode || $urandom_range(1) == 1);
    m_axi_Yi_bresp  = (m_axi_Yi_bvalid && b_given == err_beat) ? 2'b10 : 2'b00;
    m_axi_Yi_bid    = 1'b0;
    if (Yi_valid && Yi_ready) src_idx++;
    if (m_axi_Yi_awvalid && m_axi_Yi_awready) begin
      aw_log.push_back(m_axi_Yi_awaddr);
      aw_cyc.push_back(cyc);
      aw_wait = 0;
    end else if (m_axi_Yi_awvalid) begin
      aw_wait++;
    end
    if (m_axi_Yi_wvalid && m_axi_Yi_wready) begin
      wd_log.push_back(m_axi_Yi_wdata);
      ws_log.push_back(m_axi_Yi_wstrb);
      w_cyc.push_back(cyc);
    end
    if (m_axi_Yi_bvalid) begin
      b_owed--;
      b_given++;
    end
    pairs = (aw_log.size() < wd_log.size()) ? aw_log.size() : wd_log.size();
    if (pairs > pairs_seen) begin
      b_owed += pairs - pairs_seen;
      pairs_seen = pairs;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    clear_bench();
    tick();
  endtask

  task automatic start(input logic [1:0] sz, input int len);
    aw_log.delete(); wd_log.delete(); ws_log.delete(); aw_cyc.delete(); w_cyc.delete();
    src_idx = 0; pairs_seen = 0; b_given = 0; b_owed = 0; aw_wait = 0; cyc = 0;
    Ctrl_sig_Yi  = sz;
    Write_Length = 32'(len);
    Write_Begin  = 1'b1;
    tick();
    Write_Begin  = 1'b0;
  endtask

  task automatic wait_done(input int nb, input string nm);
    int n = 0;
    while (Write_Done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (Write_Done !== 1'b1) begin
      check({nm, "_done_timeout"}, 64'(Write_Done), 64'd1);
      do_reset();
    end else begin
      check({nm, "_bresp_count"}, 64'(b_given), 64'(nb));
    end
  endtask

  task automatic fill_seq(input int len);
    src.delete();
    for (int k = 1; k <= len; k++) src.push_back(64'(k));
  endtask

  // Reference: beat k carries elements k*lanes.. at byte address BASE + 8k.
  task automatic compare_model(input logic [1:0] sz, input int len, input string nm);
    int bytes, lanes, nb, n;
    logic [63:0] ed, el, em;
    logic [7:0]  es;
    logic [47:0] ea;
    bytes = (sz == 2'd0) ? 2 : (sz == 2'd1) ? 4 : 8;
    lanes = 8 / bytes;
    nb    = (len + lanes - 1) / lanes;
    em    = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (bytes * 8)) - 64'd1);
    check({nm, "_naw"}, 64'(aw_log.size()), 64'(nb));
    check({nm, "_nw"}, 64'(wd_log.size()), 64'(nb));
    for (int k = 0; k < nb && k < aw_log.size() && k < wd_log.size(); k++) begin
      ed = '0;
      n  = 0;
      for (int j = 0; j < lanes; j++) begin
        if (k * lanes + j < len) begin
          el = src[k * lanes + j] & em;
          ed = ed | (el << (j * bytes * 8));
          n++;
        end
      end
      es = 8'((1 << (n * bytes)) - 1);
      ea = YBASE + 48'(k * 8);
      check({nm, "_addr"}, 64'(aw_log[k]), 64'(ea));
      check({nm, "_data"}, wd_log[k], ed);
      check({nm, "_strb"}, 64'(ws_log[k]), 64'(es));
    end
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{2'd1, 4, 2, 48'h4000_0008, 64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003, 8'hFF, 8'hFF};
    vt[1] = '{2'd0, 5, 2, 48'h4000_0008, 64'h0004_0003_0002_0001, 64'h0000_0000_0000_0005, 8'hFF, 8'h03};
    vt[2] = '{2'd2, 3, 3, 48'h4000_0010, 64'h1, 64'h3, 8'hFF, 8'hFF};
    vt[3] = '{2'd3, 2, 2, 48'h4000_0008, 64'h1, 64'h2, 8'hFF, 8'hFF};
    vt[4] = '{2'd1, 3, 2, 48'h4000_0008, 64'h0000_0002_0000_0001, 64'h3, 8'hFF, 8'h0F};
    vt[5] = '{2'd0, 1, 1, 48'h4000_0000, 64'h1, 64'h1, 8'h03, 8'h03};
    vt[6] = '{2'd0, 8, 2, 48'h4000_0008, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 8'hFF, 8'hFF};

    rstn = 1'b0; Write_Begin = 1'b0; Write_Length = '0; Ctrl_sig_Yi = '0;
    Yi_valid = 1'b0; Yi_data = '0; m_axi_Yi_awready = 1'b0; m_axi_Yi_wready = 1'b0;
    m_axi_Yi_bid = 1'b0; m_axi_Yi_bresp = '0; m_axi_Yi_bvalid = 1'b0;
    b_hold = 1'b0; rnd_mode = 1'b0; err_beat = -1; aw_dly = 0;
    clear_bench();
    do_reset();

    // Reset state and constant AXI fields
    check("rst_yi_ready", 64'(Yi_ready), 64'd0);
    check("rst_awvalid", 64'(m_axi_Yi_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_axi_Yi_wvalid), 64'd0);
    check("rst_done", 64'(Write_Done), 64'd0);
    check("rst_err", 64'(Write_Err), 64'd0);
    check("tie_awid", 64'(m_axi_Yi_awid), 64'd0);
    check("tie_awlen", 64'(m_axi_Yi_awlen), 64'd0);
    check("tie_awsize", 64'(m_axi_Yi_awsize), 64'd3);
    check("tie_awburst", 64'(m_axi_Yi_awburst), 64'd1);
    check("tie_awlock", 64'(m_axi_Yi_awlock), 64'd0);
    check("tie_awcache", 64'(m_axi_Yi_awcache), 64'h3);
    check("tie_awprot", 64'(m_axi_Yi_awprot), 64'd0);
    check("tie_awqos", 64'(m_axi_Yi_awqos), 64'd0);
    check("tie_wlast", 64'(m_axi_Yi_wlast), 64'd1);
    check("tie_bready", 64'(m_axi_Yi_bready), 64'd1);

    // Zero-length run: done one cycle after start, no traffic
    src.delete();
    start(2'd1, 0);
    check("len0_done", 64'(Write_Done), 64'd1);
    repeat (3) tick();
    check("len0_naw", 64'(aw_log.size()), 64'd0);
    check("len0_nw", 64'(wd_log.size()), 64'd0);
    check("len0_done_hold", 64'(Write_Done), 64'd1);

    // Directed vector table
    for (int t = 0; t < 7; t++) begin
      fill_seq(vt[t].len);
      start(vt[t].size, vt[t].len);
      check("vec_done_drop", 64'(Write_Done), 64'd0);
      wait_done(vt[t].nbeats, "vec");
      check("vec_naw", 64'(aw_log.size()), 64'(vt[t].nbeats));
      check("vec_nw", 64'(wd_log.size()), 64'(vt[t].nbeats));
      if (aw_log.size() > 0 && wd_log.size() > 0) begin
        check("vec_addr_first", 64'(aw_log[0]), 64'(YBASE));
        check("vec_addr_last", 64'(aw_log[aw_log.size() - 1]), 64'(vt[t].addr_last));
        check("vec_data_first", wd_log[0], vt[t].data_first);
        check("vec_data_last", wd_log[wd_log.size() - 1], vt[t].data_last);
        check("vec_strb_first", 64'(ws_log[0]), 64'(vt[t].strb_first));
        check("vec_strb_last", 64'(ws_log[ws_log.size() - 1]), 64'(vt[t].strb_last));
      end
    end

    // AW accepted 3 cycles after W
    aw_dly = 3;
    fill_seq(1);
    start(2'd2, 1);
    wait_done(1, "awdly");
    aw_dly = 0;
    check("awdly_naw", 64'(aw_log.size()), 64'd1);
    check("awdly_nw", 64'(wd_log.size()), 64'd1);
    if (aw_cyc.size() > 0 && w_cyc.size() > 0)
      check("awdly_gap", 64'(aw_cyc[0] - w_cyc[0]), 64'd3);

    // Outstanding limit with B withheld
    b_hold = 1'b1;
    fill_seq(4);
    start(2'd2, 4);
    repeat (20) tick();
    check("hold_naw", 64'(aw_log.size()), 64'd2);
    check("hold_nw", 64'(wd_log.size()), 64'd2);
    check("hold_ready", 64'(Yi_ready), 64'd0);
    b_hold = 1'b0;
    tick();
    check("hold_ready_after_b", 64'(Yi_ready), 64'd1);
    wait_done(4, "hold");
    check("hold_naw_final", 64'(aw_log.size()), 64'd4);

    // Error response on the second beat
    err_beat = 1;
    fill_seq(3);
    start(2'd2, 3);
    wait_done(3, "err");
    check("err_at_done", 64'(Write_Err), 64'(EXP_ERR));
    repeat (3) tick();
    check("err_sticky", 64'(Write_Err), 64'(EXP_ERR));
    err_beat = -1;
    fill_seq(1);
    start(2'd2, 1);
    check("err_clear_on_begin", 64'(Write_Err), 64'd0);
    wait_done(1, "err2");

    // Reset in the middle of a run
    err_beat = 0;
    fill_seq(4);
    start(2'd2, 4);
    repeat (5) tick();
    check("mid_err_before_rst", 64'(Write_Err), 64'(EXP_ERR));
    rstn = 1'b0;
    tick();
    check("mid_rst_ready", 64'(Yi_ready), 64'd0);
    check("mid_rst_awvalid", 64'(m_axi_Yi_awvalid), 64'd0);
    check("mid_rst_wvalid", 64'(m_axi_Yi_wvalid), 64'd0);
    check("mid_rst_done", 64'(Write_Done), 64'd0);
    check("mid_rst_err", 64'(Write_Err), 64'd0);
    err_beat = -1;
    rstn = 1'b1;
    clear_bench();
    tick();
    check("mid_rst_idle_ready", 64'(Yi_ready), 64'd0);

    // Randomized runs against the reference model
    rnd_mode = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [1:0] sz;
      int len;
      sz  = 2'($urandom_range(3));
      len = $urandom_range(20, 1);
      src.delete();
      for (int k = 0; k < len; k++) src.push_back({$urandom, $urandom});
      start(sz, len);
      wait_done((len + (8 / ((sz == 2'd0) ? 2 : (sz == 2'd1) ? 4 : 8)) - 1) /
                (8 / ((sz == 2'd0) ? 2 : (sz == 2'd1) ? 4 : 8)), "rnd");
      compare_model(sz, len, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
